// File: rtl/dts_slip_align_ctrl.sv
// Per-channel word-alignment controller: resync requests -> one-cycle gearbox slips with holdoff.
// Optional lifetime slip counters are built when DTS_SLIP_STATS_EN is defined.
module dts_slip_align_ctrl #(
  parameter int N_CHANNELS     = 12,
  parameter int HOLDOFF_CYCLES = 128,
  parameter int MAX_SLIPS      = 160,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CHANNELS-1:0]       enable,
  input  logic [N_CHANNELS-1:0]       resync_n,
  input  logic [N_CHANNELS-1:0]       def_locked,
  input  logic [N_CHANNELS-1:0]       clear,
  output logic [N_CHANNELS-1:0]       gearbox_slip,
  output logic [N_CHANNELS-1:0]       rx_locked,
  output logic [N_CHANNELS-1:0]       fail,
  output logic [N_CHANNELS*CNT_W-1:0] attempts,
  output logic [N_CHANNELS*CNT_W-1:0] slip_total
);

  // state  | meaning
  // S_IDLE | locked or waiting for a resync request
  // S_SLIP | slip pulse on the GTY
  // S_HOLD | holdoff after a slip, counting down
  // S_FAIL | MAX_SLIPS exhausted, waiting for clear
  typedef enum logic [1:0] {S_IDLE, S_SLIP, S_HOLD, S_FAIL} state_t;

  localparam int HCW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HCW-1:0]   HOLD_LOAD = HCW'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_ATT   = CNT_W'(MAX_SLIPS);

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    state_t           state;
    logic [HCW-1:0]   hold_cnt;
    logic [CNT_W-1:0] att;
    logic [CNT_W-1:0] att_eff;
    logic             slip_q, lock_q, fail_q;
    logic             req, slip_start;

    // def_locked zeroes the attempt count in the same cycle a request is evaluated
    assign att_eff    = def_locked[i] ? '0 : att;
    assign req        = enable[i] & ~resync_n[i] & ~clear[i];
    assign slip_start = (state == S_IDLE) && req && (att_eff < MAX_ATT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= S_IDLE;
        hold_cnt <= '0;
        att      <= '0;
        slip_q   <= 1'b0;
        lock_q   <= 1'b1;
        fail_q   <= 1'b0;
      end else begin
        slip_q <= 1'b0;
        case (state)
          S_IDLE: begin
            if (clear[i]) begin
              att <= '0;
            end else if (slip_start) begin
              state  <= S_SLIP;
              att    <= att_eff + 1'b1;
              slip_q <= 1'b1;
              lock_q <= 1'b0;
            end else if (req) begin
              state  <= S_FAIL;
              att    <= att_eff;
              fail_q <= 1'b1;
              lock_q <= 1'b0;
            end else begin
              att <= att_eff;
            end
          end
          S_SLIP: begin
            hold_cnt <= HOLD_LOAD;
            state    <= S_HOLD;
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              state  <= S_IDLE;
              lock_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          S_FAIL: begin
            if (clear[i]) begin
              state  <= S_IDLE;
              att    <= '0;
              fail_q <= 1'b0;
              lock_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign gearbox_slip[i]              = slip_q;
    assign rx_locked[i]                 = lock_q;
    assign fail[i]                      = fail_q;
    assign attempts[i*CNT_W +: CNT_W]   = att;

`ifdef DTS_SLIP_STATS_EN
    logic [CNT_W-1:0] total;
    logic             clr_stats;

    assign clr_stats = clear[i] && ((state == S_IDLE) || (state == S_FAIL));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        total <= '0;
      end else if (clr_stats) begin
        total <= '0;
      end else if (slip_start && (total != '1)) begin
        total <= total + 1'b1;
      end
    end

    assign slip_total[i*CNT_W +: CNT_W] = total;
`else
    assign slip_total[i*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule

// File: tb/tb_dts_slip_align_ctrl.sv
// Directed self-checking bench for dts_slip_align_ctrl (HOLDOFF 128, MAX_SLIPS 4, CNT_W 4).
module tb_dts_slip_align_ctrl;
  localparam int N  = 12;
  localparam int H  = 128;
  localparam int MS = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  enable, resync_n, def_locked, clear;
  logic [N-1:0]  gearbox_slip, rx_locked, fail;
  logic [N*CW-1:0] attempts, slip_total;

  int errors = 0;
  int checks = 0;

  dts_slip_align_ctrl #(
    .N_CHANNELS(N), .HOLDOFF_CYCLES(H), .MAX_SLIPS(MS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resync_n(resync_n),
    .def_locked(def_locked), .clear(clear), .gearbox_slip(gearbox_slip),
    .rx_locked(rx_locked), .fail(fail), .attempts(attempts), .slip_total(slip_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic slip;
    logic lock;
  } vec_t;
  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] att_of(input int ch);
    return attempts[ch*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] tot_of(input int ch);
    return slip_total[ch*CW +: CW];
  endfunction

  task automatic request(input int ch);
    resync_n[ch] = 1'b0;
    step();
    resync_n[ch] = 1'b1;
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    while (rx_locked[ch] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("wait_idle_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int slips, low_cnt, max_att;
    int slip_at[$];
    logic others_moved;
    logic [CW-1:0] exp_tot;

    tbl[0] = '{1,   1'b1, 1'b0};
    tbl[1] = '{2,   1'b0, 1'b0};
    tbl[2] = '{64,  1'b0, 1'b0};
    tbl[3] = '{128, 1'b0, 1'b0};
    tbl[4] = '{129, 1'b0, 1'b0};
    tbl[5] = '{130, 1'b0, 1'b1};
    tbl[6] = '{131, 1'b0, 1'b1};

    rst_n = 1'b0; enable = '1; resync_n = '1; def_locked = '0; clear = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_slip", 32'(gearbox_slip), 32'(0));
    chk("rst_locked", 32'(rx_locked), 32'(12'hfff));
    chk("rst_fail", 32'(fail), 32'(0));
    chk("rst_attempts", attempts[31:0], 32'(0));
    chk("rst_total", slip_total[31:0], 32'(0));

    // test 1: single request on channel 0, table of timing checkpoints
    slips = 0; low_cnt = 0; others_moved = 1'b0;
    resync_n[0] = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      step();
      if (c == 1) resync_n[0] = 1'b1;
      if (gearbox_slip[0]) slips++;
      if (!rx_locked[0]) low_cnt++;
      if (gearbox_slip[N-1:1] != '0 || rx_locked[N-1:1] != '1) others_moved = 1'b1;
      for (int t = 0; t < 7; t++) begin
        if (tbl[t].cyc == c) begin
          chk($sformatf("t1_slip_c%0d", c), 32'(gearbox_slip[0]), 32'(tbl[t].slip));
          chk($sformatf("t1_lock_c%0d", c), 32'(rx_locked[0]), 32'(tbl[t].lock));
        end
      end
    end
    chk("t1_slip_count", 32'(slips), 32'(1));
    chk("t1_lock_low_cycles", 32'(low_cnt), 32'(H + 1));
    chk("t1_others_quiet", 32'(others_moved), 32'(0));
    chk("t1_attempts", 32'(att_of(0)), 32'(1));

    // test 2: channel 3 held low until FAIL
    resync_n[3] = 1'b0;
    for (int c = 0; c < 700; c++) begin
      step();
      if (gearbox_slip[3]) slip_at.push_back(c);
    end
    chk("t2_slip_count", 32'(slip_at.size()), 32'(MS));
    for (int s = 1; s < slip_at.size(); s++)
      chk($sformatf("t2_spacing_%0d", s), 32'(slip_at[s] - slip_at[s-1]), 32'(H + 2));
    chk("t2_fail", 32'(fail[3]), 32'(1));
    chk("t2_fail_locked", 32'(rx_locked[3]), 32'(0));
    chk("t2_attempts_max", 32'(att_of(3)), 32'(MS));
    resync_n[3] = 1'b1;
    step();
    chk("t2_fail_sticky", 32'(fail[3]), 32'(1));
    clear[3] = 1'b1;
    step();
    clear[3] = 1'b0;
    chk("t2_clear_fail", 32'(fail[3]), 32'(0));
    chk("t2_clear_attempts", 32'(att_of(3)), 32'(0));
    chk("t2_clear_locked", 32'(rx_locked[3]), 32'(1));

    // test 3: channel 5 requests and clear during HOLD are ignored
    slips = 0;
    resync_n[5] = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      step();
      resync_n[5] = (c < 125) ? logic'(c % 2) : 1'b1;
      clear[5] = (c == 50);
      if (gearbox_slip[5]) slips++;
    end
    chk("t3_slip_count", 32'(slips), 32'(1));
    chk("t3_back_idle", 32'(rx_locked[5]), 32'(1));
    chk("t3_clear_ignored_hold", 32'(att_of(5)), 32'(1));
    enable[5] = 1'b0;
    resync_n[5] = 1'b0;
    step(); step(); step();
    chk("t3_disabled_no_slip", 32'(gearbox_slip[5]), 32'(0));
    chk("t3_disabled_locked", 32'(rx_locked[5]), 32'(1));
    resync_n[5] = 1'b1;
    enable[5] = 1'b1;
    request(5);
    chk("t3_next_slip", 32'(gearbox_slip[5]), 32'(1));
    chk("t3_attempts2", 32'(att_of(5)), 32'(2));
    wait_idle(5);

    // test 4: two slips on channel 2, then def_locked zeroes attempts
    request(2); wait_idle(2);
    request(2); wait_idle(2);
    chk("t4_attempts2", 32'(att_of(2)), 32'(2));
    def_locked[2] = 1'b1;
    step();
    def_locked[2] = 1'b0;
    step();
    chk("t4_attempts0", 32'(att_of(2)), 32'(0));
`ifdef DTS_SLIP_STATS_EN
    exp_tot = CW'(2);
`else
    exp_tot = '0;
`endif
    chk("t4_total", 32'(tot_of(2)), 32'(exp_tot));

    // test 5: async reset midway through a HOLD on channel 7
    request(7);
    repeat (60) step();
    chk("t5_in_hold", 32'(rx_locked[7]), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_locked", 32'(rx_locked), 32'(12'hfff));
    chk("t5_rst_slip", 32'(gearbox_slip), 32'(0));
    chk("t5_rst_attempts", attempts[31:0], 32'(0));
    chk("t5_rst_total", slip_total[31:0], 32'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("t5_idle_locked", 32'(rx_locked[7]), 32'(1));
    request(7);
    chk("t5_slip_after_reset", 32'(gearbox_slip[7]), 32'(1));
    wait_idle(7);

    // test 6: 20 slips on channel 9 with def_locked between them
    max_att = 0;
    for (int s = 0; s < 20; s++) begin
      request(9);
      if (int'(att_of(9)) > max_att) max_att = int'(att_of(9));
      wait_idle(9);
      def_locked[9] = 1'b1;
      step();
      def_locked[9] = 1'b0;
      if (int'(att_of(9)) > max_att) max_att = int'(att_of(9));
    end
    step();
    chk("t6_attempts_max", 32'(max_att), 32'(1));
`ifdef DTS_SLIP_STATS_EN
    exp_tot = '1;
`else
    exp_tot = '0;
`endif
    chk("t6_total_sat", 32'(tot_of(9)), 32'(exp_tot));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
